// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter.
// Holds the FSM state encoding and the grant-index width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LOAD,
        ARB_WAIT_START,
        ARB_WAIT_DONE
    } arb_state_e;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and transmitter-side signals of the UART transmit arbiter.
// The master modport is the arbiter; slave is everything around it.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    localparam int IW = grant_w(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         tx_send;
    logic [DATA_BITS-1:0]         tx_data_in;
    logic                         tx_busy;
    logic                         grant_valid;
    logic [IW-1:0]                grant_id;
    logic                         err_timeout;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_send, tx_data_in,
        output grant_valid, grant_id, err_timeout
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_send, tx_data_in,
        input  grant_valid, grant_id, err_timeout
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr+1,
// wrapping, wins.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               any
);

    always_comb begin
        logic [IW-1:0] j;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = IW'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART transmitter; holds the grant
// across a packet and gives up if the transmitter never goes busy.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst,
    uart_tx_arbiter_if.master bus
);

    localparam int IW = grant_w(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic                 gv_q, gv_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 send_q, send_d;
    logic                 err_q, err_d;
    logic                 last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic [NUM_REQ-1:0]   ready;
    logic                 accept;
    logic [DATA_BITS-1:0] sel_data;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        ready = '0;
        for (int g = 0; g < NUM_REQ; g++) begin
            ready[g] = (state_q == ARB_LOAD) && !bus.tx_busy
                       && (grant_q == IW'(g));
        end
    end

    assign accept   = |(ready & bus.req_valid);
    assign sel_data = bus.req_data[int'(grant_q)*DATA_BITS +: DATA_BITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            gv_q    <= 1'b0;
            data_q  <= '0;
            send_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            data_q  <= data_d;
            send_q  <= send_d;
            err_q   <= err_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        gv_d    = gv_q;
        data_d  = data_q;
        send_d  = 1'b0;
        err_d   = 1'b0;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    gv_d    = 1'b1;
                    state_d = ARB_LOAD;
                end
            end
            ARB_LOAD: begin
                if (accept) begin
                    data_d  = sel_data;
                    send_d  = 1'b1;
                    last_d  = bus.req_last[grant_q];
                    cnt_d   = '0;
                    state_d = ARB_WAIT_START;
                end
            end
            ARB_WAIT_START: begin
                // Pulse lands exactly BUSY_TIMEOUT cycles after tx_send.
                if (bus.tx_busy) begin
                    state_d = ARB_WAIT_DONE;
                end else if (cnt_q >= CW'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    gv_d    = 1'b0;
                    ptr_d   = grant_q;
                    state_d = ARB_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ARB_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        ptr_d   = grant_q;
                        gv_d    = 1'b0;
                        state_d = ARB_IDLE;
                    end else begin
                        state_d = ARB_LOAD;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.req_ready   = ready;
    assign bus.tx_send     = send_q;
    assign bus.tx_data_in  = data_q;
    assign bus.grant_valid = gv_q;
    assign bus.grant_id    = grant_q;
    assign bus.err_timeout = err_q;

endmodule
